// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (MUL..REMU).
// Ports: clk, rst_n, in_valid/in_ready/op/a/b/tag_in request, kill flush,
//   out_valid/out_ready/result/tag_out response.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] tag_out
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [2:0]         op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   mb_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic             is_div, sa, sb, neg_a, neg_b, neg_in;
   logic             div0, ovf;
   logic [WIDTH-1:0] abs_a, abs_b, fast_res;

   assign in_ready = (state == IDLE);

   // Signedness per funct3: MULH/MULHSU/DIV/REM sign-extend rs1,
   // only MULH/DIV/REM sign-extend rs2. MUL low half is sign-agnostic.
   assign is_div = op[2];
   assign sa     = is_div ? ~op[0] : (op[1] ^ op[0]);
   assign sb     = is_div ? ~op[0] : (op[1:0] == 2'b01);
   assign neg_a  = sa & a[WIDTH-1];
   assign neg_b  = sb & b[WIDTH-1];
   assign abs_a  = neg_a ? -a : a;
   assign abs_b  = neg_b ? -b : b;
   // Remainder takes the dividend sign; everything else XORs both.
   assign neg_in = (is_div & op[1]) ? neg_a : (neg_a ^ neg_b);

   assign div0 = is_div & (b == '0);
   assign ovf  = is_div & ~op[0] & (a == MIN) & (&b);
   always_comb begin
      fast_res = '0;
      if (div0)
         fast_res = op[1] ? a : '1;
      else
         fast_res = op[1] ? '0 : a;
   end

   // Shift-add: multiplier in low half, product grows from the top.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, mb_q} : '0);
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Restoring divide: remainder in high half, quotient shifts in low.
   logic [WIDTH:0]     div_sh, div_diff;
   logic [2*WIDTH-1:0] div_next;
   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, mb_q};
   assign div_next = div_diff[WIDTH]
                   ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   logic [2*WIDTH-1:0] mul_full;
   logic [WIDTH-1:0]   quo, rem, fix_res;
   assign mul_full = neg_q ? -acc : acc;
   assign quo      = acc[WIDTH-1:0];
   assign rem      = acc[2*WIDTH-1:WIDTH];

   always_comb begin
      fix_res = '0;
      unique case (op_q)
         3'd0:                fix_res = mul_full[WIDTH-1:0];
         3'd1, 3'd2, 3'd3:    fix_res = mul_full[2*WIDTH-1:WIDTH];
         3'd4, 3'd5:          fix_res = neg_q ? -quo : quo;
         default:             fix_res = neg_q ? -rem : rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         tag_out   <= '0;
         cnt       <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         mb_q      <= '0;
         acc       <= '0;
      end else if (kill) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q    <= op;
                  neg_q   <= neg_in;
                  tag_out <= tag_in;
                  cnt     <= '0;
                  if (div0 | ovf) begin
                     result    <= fast_res;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     acc   <= is_div ? {{WIDTH{1'b0}}, abs_a}
                                     : {{WIDTH{1'b0}}, abs_b};
                     mb_q  <= is_div ? abs_b : abs_a;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= op_q[2] ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1))
                  state <= FIX;
            end
            FIX: begin
               result    <= fix_res;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit (WIDTH=32).
// Checks results, tags, latency, backpressure, kill and async reset.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [4:0]  tag_in;
   logic        kill;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  tag_out;

   muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .tag_in(tag_in),
      .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .tag_out(tag_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int compared = 0;
   int mism     = 0;

   task automatic chk(input string nm, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %h expected %h", nm, obs, exp);
      end
   endtask

   // Latency counts the accepting edge as edge 1.
   task automatic run(input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] t,
                      input logic [31:0] er, input int el,
                      input bit hold);
      exp_t e;
      int n;
      @(negedge clk);
      chk("pre_ready", {31'd0, in_ready}, 32'd1);
      op = o; a = x; b = y; tag_in = t;
      in_valid = 1'b1;
      out_ready = !hold;
      e.res = er; e.tag = t; e.lat = el;
      sb.push_back(e);
      n = 0;
      do begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         n++;
      end while (!out_valid && n < 100);
      e = sb.pop_front();
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("latency", n, e.lat);
      chk("result", result, e.res);
      chk("tag", {27'd0, tag_out}, {27'd0, e.tag});
      if (!hold) begin
         @(posedge clk); #1;
         chk("valid_drop", {31'd0, out_valid}, 32'd0);
      end
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
      tag_in = '0; kill = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_tag", {27'd0, tag_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run(3'd0, 32'd7, 32'hFFFF_FFF9, 5'd3, 32'hFFFF_FFCF, 34, 0);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 34, 0);
      run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 34, 0);
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 34, 0);
      run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, 0);
      run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34, 0);
      run(3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 34, 0);
      run(3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 34, 0);
      run(3'd5, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 0);
      run(3'd6, 32'd5, 32'd0, 5'd13, 32'd5, 1, 0);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 0);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1, 0);

      // Backpressure
      run(3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 34, 1);
      repeat (10) begin
         @(posedge clk); #1;
         chk("bp_result", result, 32'd2);
         chk("bp_tag", {27'd0, tag_out}, 32'd9);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

      // Kill during CALC
      @(negedge clk);
      op = 3'd0; a = 32'd5; b = 32'd6; tag_in = 5'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("kill_accepted", {31'd0, in_ready}, 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill_ready", {31'd0, in_ready}, 32'd1);
      chk("kill_valid", {31'd0, out_valid}, 32'd0);
      chk("kill_result_kept", result, 32'd2);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("kill_no_output", seen, 0);

      // Request presented with kill is dropped
      @(negedge clk);
      in_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      chk("kill_req_dropped", {31'd0, in_ready}, 32'd1);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      op = 3'd5; a = 32'd100; b = 32'd7; tag_in = 5'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 34, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mism);
      $finish;
   end
endmodule
